// File: rtl/wb_pkg.sv
// Shared constants and request type for the register-file write-back path.
package wb_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 3;

  localparam int SRC_LOAD = 0;
  localparam int SRC_LWI  = 1;
  localparam int SRC_JMP  = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant, search starts at the internal
// pointer and the pointer moves just past each winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;

  // Outer loop walks distance from the pointer so the nearest requester wins.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((i - int'(ptr) + N) % N) == k)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: round-robin access to the register file write port
// plus a pending-write scoreboard for decode hazard detection.
module regfile_wb_arbiter
  import wb_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*REG_AW-1:0] req_rd,
  input  logic [NUM_SRC*XLEN-1:0]   req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [REG_AW-1:0]         rs1,
  input  logic [REG_AW-1:0]         rs2,
  output logic                      hazard_stall,
  output logic [2**REG_AW-1:0]      pending
);

  logic [NUM_SRC-1:0]   arb_req;
  logic [NUM_SRC-1:0]   grant;
  wb_req_t              sel;
  logic                 any_grant;
  logic                 do_write;
  logic [2**REG_AW-1:0] pending_next;

  // Masking requests during reset keeps req_ready low for the whole reset cycle.
  assign arb_req = reset ? '0 : req_valid;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (arb_req),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel       = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        any_grant = 1'b1;
        sel.rd    = req_rd[i*REG_AW +: REG_AW];
        sel.data  = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 grants are consumed but never reach the register file.
  assign do_write = any_grant && (sel.rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= do_write;
      if (do_write) begin
        rf_waddr <= sel.rd;
        rf_wdata <= sel.data;
      end
    end
  end

  // Set is applied after clear so a newly issued producer of the same rd stays outstanding.
  always_comb begin
    pending_next = pending;
    if (do_write) begin
      pending_next[sel.rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign hazard_stall = ((rs1 != '0) && pending[rs1]) || ((rs2 != '0) && pending[rs2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC-1:0]        req_valid;
  logic [NUM_SRC*REG_AW-1:0] req_rd;
  logic [NUM_SRC*XLEN-1:0]   req_data;
  logic [NUM_SRC-1:0]        req_ready;
  logic                      rf_we;
  logic [REG_AW-1:0]         rf_waddr;
  logic [XLEN-1:0]           rf_wdata;
  logic                      issue_valid;
  logic [REG_AW-1:0]         issue_rd;
  logic [REG_AW-1:0]         rs1;
  logic [REG_AW-1:0]         rs2;
  logic                      hazard_stall;
  logic [2**REG_AW-1:0]      pending;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .hazard_stall (hazard_stall),
    .pending      (pending)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Reference model: plain integers and a bit array of outstanding registers.
  int        m_ptr = 0;
  bit [31:0] m_pend = '0;
  bit        m_we = 1'b0;
  bit [4:0]  m_waddr = '0;
  bit [31:0] m_wdata = '0;
  bit        m_ok = 1'b0;

  function automatic int model_grant();
    int s;
    if (reset) return -1;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = (m_ptr + k) % NUM_SRC;
      if (req_valid[s]) return s;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_update
    int g;
    int rd;
    g = model_grant();
    if (reset) begin
      m_ptr = 0; m_pend = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_ok = 1'b1;
    end else begin
      m_we = 1'b0;
      if (g >= 0) begin
        rd = int'(req_rd[g*REG_AW +: REG_AW]);
        m_ptr = (g + 1) % NUM_SRC;
        if (rd != 0) begin
          m_we    = 1'b1;
          m_waddr = 5'(rd);
          m_wdata = req_data[g*XLEN +: XLEN];
          m_pend[rd] = 1'b0;
        end
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    int g;
    bit exp_stall;
    if (m_ok) begin
      g = model_grant();
      exp_stall = (rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]);
      check_output("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      check_output("hazard_stall", 32'(hazard_stall), 32'(exp_stall));
      check_output("pending", pending, m_pend);
      check_output("rf_we", 32'(rf_we), 32'(m_we));
      if (m_we) begin
        check_output("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        check_output("rf_wdata", rf_wdata, m_wdata);
      end
    end
  end

  task automatic apply_stimulus(input logic [2:0] rv,
                                input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic iv, input logic [4:0] ird,
                                input logic [4:0] r1, input logic [4:0] r2);
    req_valid   = rv;
    req_rd      = {rd2, rd1, rd0};
    req_data    = {d2, d1, d0};
    issue_valid = iv;
    issue_rd    = ird;
    rs1         = r1;
    rs2         = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    apply_stimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_output("idle_rf_we", 32'(rf_we), 32'd0);
    check_output("idle_pending", pending, 32'd0);
    check_output("idle_ready", 32'(req_ready), 32'd0);
    check_output("idle_stall", 32'(hazard_stall), 32'd0);

    // Single request to r5.
    apply_stimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd5, 5'd5, 0);
    tick();
    check_output("single_pending_set", pending, 32'h0000_0020);
    check_output("single_stall_hi", 32'(hazard_stall), 32'd1);
    apply_stimulus(3'b001, 5'd5, 0, 0, 32'hDEADBEEF, 0, 0, 1'b0, 0, 5'd5, 0);
    check_output("single_ready", 32'(req_ready), 32'b001);
    tick();
    check_output("single_rf_we", 32'(rf_we), 32'd1);
    check_output("single_waddr", 32'(rf_waddr), 32'd5);
    check_output("single_wdata", rf_wdata, 32'hDEADBEEF);
    check_output("single_pending_clr", pending, 32'd0);
    check_output("single_stall_lo", 32'(hazard_stall), 32'd0);

    // Jump-link alone brings the pointer back to 0.
    apply_stimulus(3'b100, 0, 0, 5'd9, 0, 0, 32'h0000_0900, 1'b0, 0, 0, 0);
    check_output("jmp_ready", 32'(req_ready), 32'b100);
    tick();
    check_output("jmp_waddr", 32'(rf_waddr), 32'd9);

    // Contention: all three valid for three cycles.
    apply_stimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1'b0, 0, 0, 0);
    check_output("cont_ready0", 32'(req_ready), 32'b001);
    tick();
    check_output("cont_waddr0", 32'(rf_waddr), 32'd1);
    check_output("cont_ready1", 32'(req_ready), 32'b010);
    tick();
    check_output("cont_waddr1", 32'(rf_waddr), 32'd2);
    check_output("cont_ready2", 32'(req_ready), 32'b100);
    tick();
    check_output("cont_waddr2", 32'(rf_waddr), 32'd3);
    check_output("cont_wdata2", rf_wdata, 32'hC);

    // x0 write from lwi: consumed, no write, pointer moves to 2.
    apply_stimulus(3'b010, 0, 5'd0, 0, 0, 32'h1234, 0, 1'b0, 0, 0, 0);
    check_output("x0_ready", 32'(req_ready), 32'b010);
    tick();
    check_output("x0_rf_we", 32'(rf_we), 32'd0);
    check_output("x0_pending", pending, 32'd0);

    // Fairness wrap from pointer 2.
    apply_stimulus(3'b101, 5'd10, 0, 5'd11, 32'h10, 0, 32'h11, 1'b0, 0, 0, 0);
    check_output("wrap_ready0", 32'(req_ready), 32'b100);
    tick();
    check_output("wrap_waddr0", 32'(rf_waddr), 32'd11);
    apply_stimulus(3'b001, 5'd10, 0, 0, 32'h10, 0, 0, 1'b0, 0, 0, 0);
    check_output("wrap_ready1", 32'(req_ready), 32'b001);
    tick();
    check_output("wrap_waddr1", 32'(rf_waddr), 32'd10);

    // Set/clear collision on r7.
    apply_stimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd7, 0, 0);
    tick();
    check_output("coll_pending_pre", pending, 32'h0000_0080);
    apply_stimulus(3'b001, 5'd7, 0, 0, 32'h77, 0, 0, 1'b1, 5'd7, 0, 5'd7);
    tick();
    check_output("coll_rf_we", 32'(rf_we), 32'd1);
    check_output("coll_waddr", 32'(rf_waddr), 32'd7);
    check_output("coll_pending", pending, 32'h0000_0080);
    check_output("coll_stall", 32'(hazard_stall), 32'd1);
    idle();
    tick();

    // Reset while a request is presented: nothing is accepted or written.
    apply_stimulus(3'b001, 5'd12, 0, 0, 32'hCC, 0, 0, 1'b1, 5'd12, 0, 0);
    reset = 1'b1;
    #1;
    check_output("rst_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    check_output("rst_rf_we", 32'(rf_we), 32'd0);
    check_output("rst_pending", pending, 32'd0);
    tick();
    check_output("rst_rf_we_after", 32'(rf_we), 32'd0);

    // Mixed traffic checked by the model alone.
    for (int n = 0; n < 40; n++) begin
      apply_stimulus(3'($urandom_range(0, 7)),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     $urandom, $urandom, $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
    end

    idle();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
